// File: rtl/median_pkg.sv
// Constants and types shared between the window generator and the median pipeline.
package median_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned WIN_SIZE       = 9;

    typedef logic [DEFAULT_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port line memory: synchronous write, combinational read of the old contents.
module line_buffer #(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: the window generator's row gating hides stale contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-stream 3x3 window generator with two line buffers; emits only full windows.
// Optional macro WINDOW_GEN_OUT_REG_EN adds one output register stage (2 clk latency).
module window_gen_3x3
    import median_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] win_0,
    output logic [DATA_W-1:0] win_1,
    output logic [DATA_W-1:0] win_2,
    output logic [DATA_W-1:0] win_3,
    output logic [DATA_W-1:0] win_4,
    output logic [DATA_W-1:0] win_5,
    output logic [DATA_W-1:0] win_6,
    output logic [DATA_W-1:0] win_7,
    output logic [DATA_W-1:0] win_8,
    output logic              win_valid,
    output logic              win_eof
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d, acc_col;
    logic [ROW_W-1:0] row_q, row_d, acc_row;
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [DATA_W-1:0] win_q [WIN_SIZE];
    logic              valid_q, eof_q;

    // sof overrides the counters so the accepted pixel is (0,0).
    always_comb begin
        acc_col = sof ? '0 : col_q;
        acc_row = sof ? '0 : row_q;
        col_d   = (acc_col == COL_LAST) ? '0 : acc_col + 1'b1;
        row_d   = acc_row;
        if (acc_col == COL_LAST) begin
            row_d = (acc_row == ROW_LAST) ? '0 : acc_row + 1'b1;
        end
    end

    // Both lines share one memory: upper half holds row r-2, lower half row r-1.
    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .DATA_W(2 * DATA_W)
    ) u_line_buffer (
        .clk  (clk),
        .we   (pix_valid),
        .addr (acc_col),
        .wdata({lb0_rd, pix_in}),
        .rdata({lb1_rd, lb0_rd})
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            for (int i = 0; i < WIN_SIZE; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            valid_q <= pix_valid && (acc_row >= ROW_W'(2)) && (acc_col >= COL_W'(2));
            eof_q   <= pix_valid && (acc_row == ROW_LAST) && (acc_col == COL_LAST);
            if (pix_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                for (int i = 0; i < 3; i++) begin
                    win_q[3*i]   <= win_q[3*i+1];
                    win_q[3*i+1] <= win_q[3*i+2];
                end
                win_q[2] <= lb1_rd;
                win_q[5] <= lb0_rd;
                win_q[8] <= pix_in;
            end
        end
    end

    logic [DATA_W-1:0] win_out [WIN_SIZE];
    logic              valid_out, eof_out;

`ifdef WINDOW_GEN_OUT_REG_EN
    logic [DATA_W-1:0] out_win_q [WIN_SIZE];
    logic              out_valid_q, out_eof_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int i = 0; i < WIN_SIZE; i++) begin
                out_win_q[i] <= '0;
            end
        end else begin
            out_valid_q <= valid_q;
            out_eof_q   <= eof_q;
            out_win_q   <= win_q;
        end
    end

    assign win_out   = out_win_q;
    assign valid_out = out_valid_q;
    assign eof_out   = out_eof_q;
`else
    assign win_out   = win_q;
    assign valid_out = valid_q;
    assign eof_out   = eof_q;
`endif

    assign win_0     = win_out[0];
    assign win_1     = win_out[1];
    assign win_2     = win_out[2];
    assign win_3     = win_out[3];
    assign win_4     = win_out[4];
    assign win_5     = win_out[5];
    assign win_6     = win_out[6];
    assign win_7     = win_out[7];
    assign win_8     = win_out[8];
    assign win_valid = valid_out;
    assign win_eof   = eof_out;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomized and directed bench for window_gen_3x3 on a 4x4 image against a frame-array model.
module tb_window_gen_3x3;

    localparam int W = 4;
    localparam int H = 4;
`ifdef WINDOW_GEN_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
    logic       win_valid, win_eof;

    window_gen_3x3 #(
        .DATA_W    (8),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_in   (pix_in),
        .pix_valid(pix_valid),
        .sof      (sof),
        .win_0    (win_0),
        .win_1    (win_1),
        .win_2    (win_2),
        .win_3    (win_3),
        .win_4    (win_4),
        .win_5    (win_5),
        .win_6    (win_6),
        .win_7    (win_7),
        .win_8    (win_8),
        .win_valid(win_valid),
        .win_eof  (win_eof)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected window for a frame where pixel(r,c) = base + 16*r + c, top-left at (r0,c0) = (0,0).
    function automatic logic [71:0] grid_win(input logic [7:0] base);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) begin
            w[71-8*i -: 8] = base + 8'(16 * (i / 3)) + 8'(i % 3);
        end
        return w;
    endfunction

    // Reference model: tracks frame position and stores pixels in a 2D image array.
    logic [7:0]  img [H][W];
    logic        ev [8];
    logic        ee [8];
    logic [71:0] ew [8];
    int          cyc = 0;
    int          mr = 0, mc = 0;
    int          exp_cnt = 0;

    initial begin
        for (int s = 0; s < 8; s++) begin
            ev[s] = 1'b0; ee[s] = 1'b0; ew[s] = '0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mr = 0; mc = 0;
                for (int s = 0; s < 8; s++) begin
                    ev[s] = 1'b0; ee[s] = 1'b0;
                end
            end else begin
                int s;
                cyc++;
                s = (cyc + LAT - 1) % 8;
                ev[s] = 1'b0; ee[s] = 1'b0;
                if (pix_valid) begin
                    if (sof) begin
                        mr = 0; mc = 0;
                    end
                    img[mr][mc] = pix_in;
                    if (mr >= 2 && mc >= 2) begin
                        ev[s] = 1'b1;
                        ee[s] = (mr == H - 1) && (mc == W - 1);
                        for (int i = 0; i < 9; i++) begin
                            ew[s][71-8*i -: 8] = img[mr-2+i/3][mc-2+i%3];
                        end
                        exp_cnt++;
                    end
                    mc++;
                    if (mc == W) begin
                        mc = 0;
                        mr = (mr == H - 1) ? 0 : mr + 1;
                    end
                end
            end
        end
    end

    // Monitor: every cycle compared against the model; valid windows also logged.
    logic [71:0] obs_q [$];
    logic        eof_q [$];

    initial begin
        forever begin
            @(negedge clk);
            begin
                int s;
                logic [71:0] got;
                s   = cyc % 8;
                got = {win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8};
                check_eq("win_valid", 72'(win_valid), 72'(ev[s]));
                check_eq("win_eof", 72'(win_eof), 72'(ee[s]));
                if (ev[s]) check_eq("win_data", got, ew[s]);
                if (win_valid) begin
                    obs_q.push_back(got);
                    eof_q.push_back(win_eof);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input logic s, input int gap);
        pix_valid = 1'b0;
        sof       = 1'b0;
        if (gap > 0) idle(gap);
        pix_valid = 1'b1;
        pix_in    = v;
        sof       = s;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // mode 0: continuous, 1: toggle plus 5-cycle gap at (2,1), 2: random gaps and values
    task automatic send_pixels(input logic [7:0] base, input int n, input logic sof_first,
                               input int mode);
        for (int k = 0; k < n; k++) begin
            int gap;
            logic [7:0] v;
            v = base + 8'(16 * (k / W)) + 8'(k % W);
            case (mode)
                0: gap = 0;
                1: gap = (k == 0) ? 0 : ((k == 9) ? 5 : 1);
                default: begin
                    gap = $urandom_range(0, 2);
                    v   = 8'($urandom);
                end
            endcase
            drive(v, sof_first && (k == 0), gap);
        end
    endtask

    function automatic int eof_count();
        int n = 0;
        foreach (eof_q[i]) if (eof_q[i]) n++;
        return n;
    endfunction

    task automatic clear_log();
        obs_q.delete();
        eof_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_win"}, {win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8},
                 72'd0);
        check_eq({tag, "_valid"}, 72'(win_valid), 72'd0);
        check_eq({tag, "_eof"}, 72'(win_eof), 72'd0);
    endtask

    initial begin
        pix_valid = 1'b0;
        pix_in    = '0;
        sof       = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Continuous frame
        clear_log();
        send_pixels(8'h00, W * H, 1'b1, 0);
        idle(4);
        check_eq("t1_count", 72'(obs_q.size()), 72'd4);
        check_eq("t1_eofs", 72'(eof_count()), 72'd1);
        if (obs_q.size() == 4) begin
            check_eq("t1_first", obs_q[0], grid_win(8'h00));
            check_eq("t1_last", obs_q[3], grid_win(8'h11));
            check_eq("t1_last_eof", 72'(eof_q[3]), 72'd1);
        end

        // Toggling valid with a long mid-line gap
        clear_log();
        send_pixels(8'h00, W * H, 1'b1, 1);
        idle(4);
        check_eq("t2_count", 72'(obs_q.size()), 72'd4);
        if (obs_q.size() == 4) begin
            check_eq("t2_first", obs_q[0], grid_win(8'h00));
            check_eq("t2_last", obs_q[3], grid_win(8'h11));
        end

        // Back-to-back frames
        clear_log();
        send_pixels(8'h00, W * H, 1'b1, 0);
        send_pixels(8'h80, W * H, 1'b1, 0);
        idle(4);
        check_eq("t3_count", 72'(obs_q.size()), 72'd8);
        check_eq("t3_eofs", 72'(eof_count()), 72'd2);
        if (obs_q.size() == 8) check_eq("t3_second_first", obs_q[4], grid_win(8'h80));

        // sof at (2,1) aborts the frame
        clear_log();
        send_pixels(8'h00, 9, 1'b1, 0);
        send_pixels(8'h40, W * H, 1'b1, 0);
        idle(4);
        check_eq("t4_count", 72'(obs_q.size()), 72'd4);
        check_eq("t4_eofs", 72'(eof_count()), 72'd1);
        if (obs_q.size() == 4) check_eq("t4_first", obs_q[0], grid_win(8'h40));

        // Asynchronous reset after (2,3), then a frame without sof
        send_pixels(8'h00, 12, 1'b1, 0);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("t5_reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(1);
        clear_log();
        send_pixels(8'h00, W * H, 1'b0, 0);
        idle(4);
        check_eq("t5_count", 72'(obs_q.size()), 72'd4);
        if (obs_q.size() == 4) check_eq("t5_first", obs_q[0], grid_win(8'h00));

        // Random frames, some truncated, some without sof
        clear_log();
        exp_cnt = 0;
        for (int f = 0; f < 25; f++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W * H - 1) : W * H;
            send_pixels(8'h00, n, $urandom_range(0, 3) != 0, 2);
        end
        idle(4);
        check_eq("rnd_count", 72'(obs_q.size()), 72'(exp_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
